// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin arbiter feeding a shared binary-to-gray converter
// One word accepted per IDLE cycle; result held in SEND until the consumer takes it.
module gray_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_gray,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    output logic [7:0]                 xfer_count,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_gray_q, out_gray_d;
    logic [IDW-1:0]     out_id_q, out_id_d;
    logic [7:0]         xfer_count_q, xfer_count_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;

    logic [WIDTH-1:0]   words [N_REQ];
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand_idx;
    int                 cand;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Search starts one past the last winner and wraps, so every requester is reached within N_REQ grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(last_grant_q) + k) % N_REQ;
            cand_idx = IDW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_gray_d   = out_gray_q;
        out_id_d     = out_id_q;
        xfer_count_d = xfer_count_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (grant_found && rst_n) begin
                    req_ready    = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
                    out_valid_d  = 1'b1;
                    out_gray_d   = bin2gray(words[grant_idx]);
                    out_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d  = 1'b0;
                    xfer_count_d = xfer_count_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_gray_q   <= '0;
            out_id_q     <= '0;
            xfer_count_q <= 8'd0;
            last_grant_q <= LAST_ID;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_gray_q   <= out_gray_d;
            out_id_q     <= out_id_d;
            xfer_count_q <= xfer_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_gray   = out_gray_q;
    assign out_id     = out_id_q;
    assign xfer_count = xfer_count_q;
    assign busy       = (state_q == SEND);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - directed self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_gray;
    logic [1:0]  out_id;
    logic [7:0]  xfer_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // ids and gray codes for words {0000,1111,0110,1011} under 1111 held from reset
    logic [1:0] exp_ids  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_gray [5] = '{4'b1110, 4'b0101, 4'b1000, 4'b0000, 4'b1110};

    gray_conv_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gray   (out_gray),
        .out_id     (out_id),
        .xfer_count (xfer_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 16'h0000;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_ready",  32'(req_ready),  32'h0);
        check("rst_valid",  32'(out_valid),  32'h0);
        check("rst_gray",   32'(out_gray),   32'h0);
        check("rst_id",     32'(out_id),     32'h0);
        check("rst_xfer",   32'(xfer_count), 32'h0);
        check("rst_busy",   32'(busy),       32'h0);
        req_valid = 4'b0000;
        do_reset();

        // single request from requester 0
        req_data  = 16'h000B;
        req_valid = 4'b0001;
        #1 check("r030_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        check("r030_valid", 32'(out_valid), 32'h1);
        check("r030_gray",  32'(out_gray),  32'hE);
        check("r030_id",    32'(out_id),    32'h0);
        check("r030_busy",  32'(busy),      32'h1);
        out_ready = 1'b1;
        tick();
        check("r030_done_valid", 32'(out_valid),  32'h0);
        check("r030_done_xfer",  32'(xfer_count), 32'h1);
        check("r030_hold_gray",  32'(out_gray),   32'hE);
        tick();
        tick();
        check("r023_idle_ready", 32'(xfer_count), 32'h1);

        // all requesters contending, consumer always ready
        req_data = {4'b0000, 4'b1111, 4'b0110, 4'b1011};
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1 check("r031_ready", 32'(req_ready), 32'(4'b0001 << exp_ids[i]));
            tick();
            check("r031_id",   32'(out_id),   32'(exp_ids[i]));
            check("r031_gray", 32'(out_gray), 32'(exp_gray[i]));
            check("r031_send_ready", 32'(req_ready), 32'h0);
            tick();
            check("r031_xfer", 32'(xfer_count), 32'(i + 1));
        end

        // grant to 2, then 1010 must yield 3 then 1
        req_valid = 4'b0100;
        #1 check("r032_g2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1010;
        tick();
        #1 check("r032_g3", 32'(req_ready), 32'h8);
        tick();
        check("r032_id3", 32'(out_id), 32'h3);
        tick();
        #1 check("r032_g1", 32'(req_ready), 32'h2);
        tick();
        check("r032_id1", 32'(out_id), 32'h1);
        tick();
        check("r032_xfer", 32'(xfer_count), 32'h8);

        // consumer stalls for 5 cycles
        req_valid = 4'b0001;
        out_ready = 1'b0;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            check("r033_gray",  32'(out_gray),  32'hE);
            check("r033_id",    32'(out_id),    32'h0);
            check("r033_busy",  32'(busy),      32'h1);
            check("r033_ready", 32'(req_ready), 32'h0);
            check("r033_valid", 32'(out_valid), 32'h1);
            tick();
        end
        check("r033_xfer_pre", 32'(xfer_count), 32'h8);
        out_ready = 1'b1;
        tick();
        check("r033_xfer",  32'(xfer_count), 32'h9);
        check("r033_idle",  32'(busy),       32'h0);
        check("r033_next",  32'(req_ready),  32'h2);
        req_valid = 4'b0000;

        // asynchronous reset while a result is pending
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        out_ready = 1'b0;
        check("r034_pre_gray", 32'(out_gray), 32'h8);
        #1 rst_n = 1'b0;
        #1;
        check("r034_valid", 32'(out_valid),  32'h0);
        check("r034_gray",  32'(out_gray),   32'h0);
        check("r034_xfer",  32'(xfer_count), 32'h0);
        check("r034_busy",  32'(busy),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req_valid = 4'b1111;
        #1 check("r034_first", 32'(req_ready), 32'h1);
        out_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        tick();
        check("r034_xfer_after", 32'(xfer_count), 32'h1);

        // wrap xfer_count at 256 transfers
        req_data = 16'h000F;
        for (int i = 0; i < 255; i++) begin
            req_valid = 4'b0001;
            tick();
            req_valid = 4'b0000;
            tick();
        end
        check("r035_wrap",   32'(xfer_count), 32'h0);
        check("r035_gray_f", 32'(out_gray),   32'h8);
        req_data  = 16'h0000;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        check("r035_gray_0", 32'(out_gray), 32'h0);
        tick();
        check("r035_xfer1", 32'(xfer_count), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
